// File: rtl/mem_responder.sv
// Single-port word memory behind a valid/ready request/response handshake with fixed latency.
// Storage is not reset; only the control FSM and response registers are.
module mem_responder #(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_wen,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wmask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  CntLoad = 4'(LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] addr_q;
    logic        wen_q;
    logic [31:0] wdata_q;
    logic [3:0]  wmask_q;
    logic        ready_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [31:0] rsp_rdata_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic        accept;
    logic        commit;
    logic        mem_we;
    logic [31:0] c_addr;
    logic        c_wen;
    logic [31:0] c_wdata;
    logic [3:0]  c_wmask;
    logic [31:0] offset;
    logic        c_err;
    logic [IdxW-1:0] c_idx;
    logic [31:0] rdata_next;

    // With LATENCY==1 the access commits on the accepting edge, so use the live request.
    always_comb begin
        accept  = req_valid && ready_q;
        c_addr  = (state_q == StIdle) ? req_addr  : addr_q;
        c_wen   = (state_q == StIdle) ? req_wen   : wen_q;
        c_wdata = (state_q == StIdle) ? req_wdata : wdata_q;
        c_wmask = (state_q == StIdle) ? req_wmask : wmask_q;
        offset  = c_addr - ADDR_BASE;
        c_err   = (c_addr[1:0] != 2'b00) || ((offset >> 2) >= DEPTH_WORDS);
        c_idx   = offset[IdxW+1:2];
        commit  = ((state_q == StIdle) && accept && (LATENCY == 1)) ||
                  ((state_q == StWait) && (cnt_q == 4'd1));
        mem_we  = commit && c_wen && !c_err;
        rdata_next = (c_wen || c_err) ? 32'h0 : mem[c_idx];
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (c_wmask[b]) mem[c_idx][8*b +: 8] <= c_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            addr_q      <= 32'h0;
            wen_q       <= 1'b0;
            wdata_q     <= 32'h0;
            wmask_q     <= 4'h0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        addr_q  <= req_addr;
                        wen_q   <= req_wen;
                        wdata_q <= req_wdata;
                        wmask_q <= req_wmask;
                        ready_q <= 1'b0;
                        if (LATENCY == 1) begin
                            state_q     <= StResp;
                            cnt_q       <= 4'd0;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= c_err;
                            rsp_rdata_q <= rdata_next;
                        end else begin
                            state_q <= StWait;
                            cnt_q   <= CntLoad;
                        end
                    end
                end
                StWait: begin
                    if (commit) begin
                        state_q     <= StResp;
                        cnt_q       <= 4'd0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= c_err;
                        rsp_rdata_q <= rdata_next;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StResp: begin
                    // Ready comes back with the handshake so the next accept lands one cycle later.
                    if (rsp_ready) begin
                        state_q     <= StIdle;
                        ready_q     <= 1'b1;
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= 32'h0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: LATENCY=2 main instance plus LATENCY=1 and 15 instances
// sharing the same request inputs for accept-spacing checks.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic        req_wen = 1'b0;
    logic [31:0] req_wdata = 32'h0;
    logic [3:0]  req_wmask = 4'h0;
    logic        rsp_ready = 1'b1;

    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        r1_ready, r1_valid, r1_err;
    logic [31:0] r1_rdata;
    logic        r15_ready, r15_valid, r15_err;
    logic [31:0] r15_rdata;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mem_responder #(.LATENCY(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_wen(req_wen), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    mem_responder #(.LATENCY(1)) dut_l1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(r1_ready),
        .req_addr(req_addr), .req_wen(req_wen), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(r1_valid), .rsp_ready(rsp_ready), .rsp_rdata(r1_rdata), .rsp_err(r1_err)
    );

    mem_responder #(.LATENCY(15)) dut_l15 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(r15_ready),
        .req_addr(req_addr), .req_wen(req_wen), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(r15_valid), .rsp_ready(rsp_ready), .rsp_rdata(r15_rdata), .rsp_err(r15_err)
    );

    // One full transaction on the main instance with rsp_ready held high from the start.
    // lat counts rising edges from the accepting edge up to the one that raises rsp_valid.
    task automatic do_req(input logic [31:0] a, input logic w, input logic [31:0] d,
                          input logic [3:0] m, output logic [31:0] rd, output logic e,
                          output int lat);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_addr = a; req_wen = w; req_wdata = d; req_wmask = m;
        rsp_ready = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            $display("FAIL accept_timeout addr=%h got ready=%b want 1", a, req_ready);
            bad++;
            total++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        lat = 1;
        @(negedge clk);
        while (!rsp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        rd = rsp_rdata;
        e  = rsp_err;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        if (req_ready !== 1'b0) begin $display("FAIL rst_ready got %b want 0", req_ready); bad++; end
        total++;
        if (rsp_valid !== 1'b0) begin $display("FAIL rst_valid got %b want 0", rsp_valid); bad++; end
        total++;
        if (rsp_err !== 1'b0) begin $display("FAIL rst_err got %b want 0", rsp_err); bad++; end
        total++;
        if (rsp_rdata !== 32'h0) begin $display("FAIL rst_rdata got %h want 0", rsp_rdata); bad++; end
        total++;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        if (req_ready !== 1'b1) begin $display("FAIL rst_ready_rise got %b want 1", req_ready); bad++; end
        total++;
    endtask

    task automatic test_write_read;
        logic [31:0] rd; logic e; int lat;
        do_req(32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, rd, e, lat);
        if (rd !== 32'h0 || e !== 1'b0) begin
            $display("FAIL wr_rsp got rdata=%h err=%b want 0/0", rd, e); bad++;
        end
        total++;
        if (lat != 2) begin $display("FAIL wr_lat got %0d want 2", lat); bad++; end
        total++;
        do_req(32'h8000_0010, 1'b0, 32'h0, 4'h0, rd, e, lat);
        if (rd !== 32'hDEAD_BEEF) begin $display("FAIL rd_data got %h want deadbeef", rd); bad++; end
        total++;
        if (e !== 1'b0) begin $display("FAIL rd_err got %b want 0", e); bad++; end
        total++;
        if (lat != 2) begin $display("FAIL rd_lat got %0d want 2", lat); bad++; end
        total++;
    endtask

    task automatic test_mask;
        logic [31:0] rd; logic e; int lat;
        do_req(32'h8000_0020, 1'b1, 32'h1122_3344, 4'hF, rd, e, lat);
        do_req(32'h8000_0020, 1'b1, 32'hAABB_CCDD, 4'b0101, rd, e, lat);
        do_req(32'h8000_0020, 1'b0, 32'h0, 4'h0, rd, e, lat);
        if (rd !== 32'h11BB_33DD) begin $display("FAIL mask_data got %h want 11bb33dd", rd); bad++; end
        total++;
        do_req(32'h8000_0020, 1'b1, 32'hFFFF_FFFF, 4'b0000, rd, e, lat);
        if (e !== 1'b0) begin $display("FAIL noop_err got %b want 0", e); bad++; end
        total++;
        do_req(32'h8000_0020, 1'b0, 32'h0, 4'h0, rd, e, lat);
        if (rd !== 32'h11BB_33DD) begin $display("FAIL noop_data got %h want 11bb33dd", rd); bad++; end
        total++;
    endtask

    task automatic test_errors;
        logic [31:0] rd; logic e; int lat;
        logic [31:0] bad_addr [3];
        bad_addr[0] = 32'h8000_0002;
        bad_addr[1] = 32'h8000_1000;
        bad_addr[2] = 32'h7FFF_FFFC;
        do_req(32'h8000_0000, 1'b1, 32'hCAFE_F00D, 4'hF, rd, e, lat);
        do_req(32'h8000_0001, 1'b1, 32'hFFFF_FFFF, 4'hF, rd, e, lat);
        if (e !== 1'b1 || rd !== 32'h0) begin
            $display("FAIL err_wr got rdata=%h err=%b want 0/1", rd, e); bad++;
        end
        total++;
        for (int i = 0; i < 3; i++) begin
            do_req(bad_addr[i], 1'b0, 32'h0, 4'h0, rd, e, lat);
            if (e !== 1'b1 || rd !== 32'h0) begin
                $display("FAIL err_rd addr=%h got rdata=%h err=%b want 0/1", bad_addr[i], rd, e);
                bad++;
            end
            total++;
        end
        do_req(32'h8000_0000, 1'b0, 32'h0, 4'h0, rd, e, lat);
        if (rd !== 32'hCAFE_F00D || e !== 1'b0) begin
            $display("FAIL err_keep got rdata=%h err=%b want cafef00d/0", rd, e); bad++;
        end
        total++;
        do_req(32'h8000_0FFC, 1'b1, 32'h1234_5678, 4'hF, rd, e, lat);
        do_req(32'h8000_0FFC, 1'b0, 32'h0, 4'h0, rd, e, lat);
        if (rd !== 32'h1234_5678 || e !== 1'b0) begin
            $display("FAIL top_word got rdata=%h err=%b want 12345678/0", rd, e); bad++;
        end
        total++;
    endtask

    task automatic test_stall;
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h8000_0010; req_wen = 1'b0; rsp_ready = 1'b0;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1;
            req_addr  = 32'h8000_0020 + 32'(i * 4);
            req_wen   = i[0];
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_BEEF || rsp_err !== 1'b0 ||
                req_ready !== 1'b0) begin
                $display("FAIL stall_hold cyc=%0d got v=%b d=%h e=%b rdy=%b want 1/deadbeef/0/0",
                         i, rsp_valid, rsp_rdata, rsp_err, req_ready);
                bad++;
            end
            total++;
        end
        req_valid = 1'b0; req_wen = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            $display("FAIL stall_release got v=%b rdy=%b want 0/1", rsp_valid, req_ready); bad++;
        end
        total++;
    endtask

    task automatic test_reset_abort;
        logic [31:0] rd; logic e; int lat; int n;
        // Reset while holding a read response: outputs must clear before any clock edge.
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h8000_0010; req_wen = 1'b0; rsp_ready = 1'b0;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0) begin
            $display("FAIL async_clr got v=%b d=%h want 0/0", rsp_valid, rsp_rdata); bad++;
        end
        total++;
        @(negedge clk);
        rst = 1'b1;
        rsp_ready = 1'b1;
        do_req(32'h8000_0030, 1'b1, 32'h0, 4'hF, rd, e, lat);
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h8000_0030; req_wen = 1'b1;
        req_wdata = 32'h0000_00FF; req_wmask = 4'hF;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
            $display("FAIL abort_outs got v=%b rdy=%b e=%b d=%h want 0/0/0/0",
                     rsp_valid, req_ready, rsp_err, rsp_rdata);
            bad++;
        end
        total++;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        do_req(32'h8000_0030, 1'b0, 32'h0, 4'h0, rd, e, lat);
        if (rd !== 32'h0 || e !== 1'b0) begin
            $display("FAIL abort_data got rdata=%h err=%b want 0/0", rd, e); bad++;
        end
        total++;
    endtask

    task automatic test_back_to_back;
        int acc [3][4];
        int na [3];
        int gap_exp [3];
        logic [2:0] rdy;
        gap_exp[0] = 3; gap_exp[1] = 2; gap_exp[2] = 16;
        for (int k = 0; k < 3; k++) begin
            na[k] = 0;
            for (int j = 0; j < 4; j++) acc[k][j] = -1000 * (j + 1);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_addr = 32'h8000_0000; req_wen = 1'b0;
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            rdy = {r15_ready, r1_ready, req_ready};
            for (int k = 0; k < 3; k++) begin
                if (rdy[k] && na[k] < 4) begin
                    acc[k][na[k]] = c;
                    na[k]++;
                end
            end
        end
        req_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            for (int j = 1; j < 3; j++) begin
                if (acc[k][j] - acc[k][j-1] != gap_exp[k]) begin
                    $display("FAIL b2b_gap inst=%0d n=%0d got %0d want %0d",
                             k, j, acc[k][j] - acc[k][j-1], gap_exp[k]);
                    bad++;
                end
                total++;
            end
        end
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_mask;
        test_errors;
        test_stall;
        test_reset_abort;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
